// File: rtl/com_bus_arbiter_i.sv
//==============================================================================
// Module   : com_bus_arbiter_i
// Purpose  : Round-robin arbiter for the instruction-side common bus. Grants
//            one cache at a time, forces a one-cycle turnaround between
//            owners and revokes ownership held for MAX_HOLD cycles.
// Ports    : clk, rst_n            - clock, async active-low reset
//            Com_Bus_Req_proc      - per-cache level-sensitive requests
//            Com_Bus_Gnt_proc      - one-hot-or-zero grant vector
//            Gnt_id                - index of current / most recent owner
//            Bus_busy              - high while any grant bit is high
//            Timeout_err           - one-cycle pulse on forced revocation
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module com_bus_arbiter_i #(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] Com_Bus_Req_proc,
    output logic [NUM_REQ-1:0] Com_Bus_Gnt_proc,
    output logic [ID_W-1:0]    Gnt_id,
    output logic               Bus_busy,
    output logic               Timeout_err
);

    localparam logic [1:0]      c_idle     = 2'd0;
    localparam logic [1:0]      c_grant    = 2'd1;
    localparam logic [1:0]      c_turn     = 2'd2;
    localparam logic [7:0]      c_max_hold = 8'(MAX_HOLD);
    // Pointer starts at the top index so requester 0 is searched first.
    localparam logic [ID_W-1:0] c_last_rst = ID_W'(NUM_REQ - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] w_gnt_nxt;
    logic [ID_W-1:0]    r_gnt_id;
    logic [ID_W-1:0]    w_gnt_id_nxt;
    logic [ID_W-1:0]    r_last;
    logic [ID_W-1:0]    w_last_nxt;
    logic [7:0]         r_hold;
    logic [7:0]         w_hold_nxt;
    logic               r_busy;
    logic               r_timeout;
    logic               w_timeout_nxt;

    logic               w_any;
    logic               w_own_req;
    logic [ID_W-1:0]    w_sel;
    logic [NUM_REQ-1:0] w_sel_oh;
    logic [7:0]         w_hold_inc;
    logic               w_hold_hit;
    int                 w_best;
    int                 w_dist;

    assign w_any     = |Com_Bus_Req_proc;
    // Only the owner's bit is set in r_gnt, so this isolates its request.
    assign w_own_req = |(Com_Bus_Req_proc & r_gnt);

    // Hold count including the cycle now ending; revoke once it reaches the limit.
    assign w_hold_inc = (r_hold == c_max_hold) ? c_max_hold : r_hold + 8'd1;
    assign w_hold_hit = (w_hold_inc == c_max_hold);

    // Round-robin pick: the requester with the smallest circular distance
    // past the last owner wins. Distance 0 is last+1, NUM_REQ-1 is last itself.
    always_comb begin
        w_sel  = r_last;
        w_best = NUM_REQ;
        w_dist = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (Com_Bus_Req_proc[i]) begin
                w_dist = (i + NUM_REQ - 1 - int'(r_last)) % NUM_REQ;
                if (w_dist < w_best) begin
                    w_best = w_dist;
                    w_sel  = ID_W'(i);
                end
            end
        end
    end

    always_comb begin
        w_sel_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sel_oh[i] = (ID_W'(i) == w_sel);
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_idle;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_last    <= c_last_rst;
            r_hold    <= 8'd0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_id  <= w_gnt_id_nxt;
            r_last    <= w_last_nxt;
            r_hold    <= w_hold_nxt;
            r_busy    <= |w_gnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle, c_turn: w_state_nxt = w_any ? c_grant : c_idle;
            c_grant: begin
                if (!w_own_req || w_hold_hit) begin
                    w_state_nxt = c_turn;
                end
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        w_gnt_nxt     = r_gnt;
        w_gnt_id_nxt  = r_gnt_id;
        w_last_nxt    = r_last;
        w_hold_nxt    = r_hold;
        w_timeout_nxt = 1'b0;
        case (r_state)
            c_idle, c_turn: begin
                if (w_any) begin
                    w_gnt_nxt    = w_sel_oh;
                    w_gnt_id_nxt = w_sel;
                    w_last_nxt   = w_sel;
                    w_hold_nxt   = 8'd0;
                end else begin
                    w_gnt_nxt    = '0;
                end
            end
            c_grant: begin
                if (!w_own_req) begin
                    // Voluntary release wins over a coincident timeout.
                    w_gnt_nxt     = '0;
                end else if (w_hold_hit) begin
                    w_gnt_nxt     = '0;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_hold_nxt    = w_hold_inc;
                end
            end
            default: w_gnt_nxt = '0;
        endcase
    end

    assign Com_Bus_Gnt_proc = r_gnt;
    assign Gnt_id           = r_gnt_id;
    assign Bus_busy         = r_busy;
    assign Timeout_err      = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_com_bus_arbiter_i.sv
//==============================================================================
// Module   : tb_com_bus_arbiter_i
// Purpose  : Self-checking bench for com_bus_arbiter_i. Two instances share
//            clock and reset: MAX_HOLD=4 (main) and MAX_HOLD=1 (boundary).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_com_bus_arbiter_i;

    typedef struct packed {
        int owner;   // -1 when nobody holds the bus
        int held;    // edges survived while owning
        int last;    // last granted index
        int id;      // expected Gnt_id
        bit to;      // expected Timeout_err
    } mdl_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] req0, req1;
    logic [3:0] gnt0, gnt1;
    logic [1:0] id0, id1;
    logic       busy0, busy1, to0, to1;

    int   n_cmp;
    int   n_err;
    mdl_t m0, m1;

    com_bus_arbiter_i #(.NUM_REQ(4), .ID_W(2), .MAX_HOLD(4)) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .Com_Bus_Req_proc (req0),
        .Com_Bus_Gnt_proc (gnt0),
        .Gnt_id           (id0),
        .Bus_busy         (busy0),
        .Timeout_err      (to0)
    );

    com_bus_arbiter_i #(.NUM_REQ(4), .ID_W(2), .MAX_HOLD(1)) u_dut1 (
        .clk              (clk),
        .rst_n            (rst_n),
        .Com_Bus_Req_proc (req1),
        .Com_Bus_Gnt_proc (gnt1),
        .Gnt_id           (id1),
        .Bus_busy         (busy1),
        .Timeout_err      (to1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a released or revoked owner leaves one empty cycle simply
    // because arbitration only happens while nobody owns the bus.
    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.owner = -1; m.held = 0; m.last = 3; m.id = 0; m.to = 1'b0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, logic [3:0] req, int maxh);
        mdl_t n;
        int   idx;
        n    = m;
        n.to = 1'b0;
        if (m.owner >= 0) begin
            if (req[m.owner[1:0]] !== 1'b1) begin
                n.owner = -1;
            end else if (m.held + 1 >= maxh) begin
                n.owner = -1;
                n.to    = 1'b1;
            end else begin
                n.held = m.held + 1;
            end
        end else begin
            for (int k = 1; k <= 4; k++) begin
                idx = (m.last + k) % 4;
                if (n.owner < 0 && req[idx[1:0]] === 1'b1) begin
                    n.owner = idx; n.held = 0; n.last = idx; n.id = idx;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [3:0] exp_gnt(mdl_t m);
        logic [3:0] g;
        g = '0;
        if (m.owner >= 0) g[m.owner[1:0]] = 1'b1;
        return g;
    endfunction

    function automatic int oh2idx(logic [3:0] g);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_gnt0"},  int'(gnt0),  int'(exp_gnt(m0)));
        chk({tag, "_id0"},   int'(id0),   m0.id);
        chk({tag, "_busy0"}, int'(busy0), (m0.owner >= 0) ? 1 : 0);
        chk({tag, "_to0"},   int'(to0),   int'(m0.to));
        chk({tag, "_gnt1"},  int'(gnt1),  int'(exp_gnt(m1)));
        chk({tag, "_id1"},   int'(id1),   m1.id);
        chk({tag, "_busy1"}, int'(busy1), (m1.owner >= 0) ? 1 : 0);
        chk({tag, "_to1"},   int'(to1),   int'(m1.to));
    endtask

    task automatic cyc(input string tag, input logic [3:0] r0, input logic [3:0] r1);
        req0 = r0;
        req1 = r1;
        @(posedge clk);
        m0 = mdl_step(m0, req0, 4);
        m1 = mdl_step(m1, req1, 1);
        #1;
        chk_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0  = '0;
        req1  = '0;
        #1;
        m0 = mdl_reset();
        m1 = mdl_reset();
        chk_all("rst");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int         q_order[$];
        int         exp_order[5];
        int         zero_run;
        int         prev_own;
        int         cnt_to;
        logic [3:0] r;
        logic [3:0] r_b;
        logic [3:0] prev_gnt;

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        req0  = '0;
        req1  = '0;
        exp_order = '{0, 1, 2, 3, 0};

        // Single requester
        do_reset();
        cyc("single", 4'b0100, 4'b0000);
        chk("single_gnt", int'(gnt0), 4);
        chk("single_id", int'(id0), 2);
        cyc("single", 4'b0100, 4'b0000);
        cyc("drop", 4'b0000, 4'b0000);
        chk("drop_gnt", int'(gnt0), 0);
        cyc("idle", 4'b0000, 4'b0000);

        // Everyone requests; an owner drops after three granted cycles
        do_reset();
        prev_gnt = '0;
        zero_run = 0;
        for (int c = 0; c < 26; c++) begin
            r = 4'b1111;
            if (m0.owner >= 0 && m0.held >= 2) r[m0.owner[1:0]] = 1'b0;
            cyc("all", r, 4'b0000);
            if (gnt0 != 4'b0000 && prev_gnt == 4'b0000) begin
                if (q_order.size() > 0) chk("all_gap", zero_run, 1);
                q_order.push_back(oh2idx(gnt0));
                zero_run = 0;
            end else if (gnt0 == 4'b0000) begin
                zero_run++;
            end
            prev_gnt = gnt0;
        end
        for (int k = 0; k < 5; k++) begin
            chk("all_order", (k < q_order.size()) ? q_order[k] : -1, exp_order[k]);
        end

        // Two permanent requesters with MAX_HOLD=4: alternate via timeouts
        prev_own = -1;
        cnt_to   = 0;
        prev_gnt = gnt0;
        for (int c = 0; c < 22; c++) begin
            cyc("fair", 4'b0011, 4'b0000);
            if (to0) cnt_to++;
            if (gnt0 != 4'b0000 && prev_gnt == 4'b0000) begin
                if (prev_own >= 0) chk("fair_alt", (oh2idx(gnt0) != prev_own) ? 1 : 0, 1);
                prev_own = oh2idx(gnt0);
            end
            prev_gnt = gnt0;
        end
        chk("fair_timeouts", (cnt_to >= 3) ? 1 : 0, 1);

        // No preemption of cache 3 by cache 0
        cyc("quiet", 4'b0000, 4'b0000);
        cyc("quiet", 4'b0000, 4'b0000);
        cyc("pre", 4'b1000, 4'b0000);
        chk("pre_gnt3", int'(gnt0), 8);
        cyc("pre", 4'b1001, 4'b0000);
        chk("pre_hold", int'(gnt0), 8);
        cyc("pre", 4'b1001, 4'b0000);
        chk("pre_hold", int'(gnt0), 8);
        cyc("pre", 4'b0001, 4'b0000);
        chk("pre_turn", int'(gnt0), 0);
        cyc("pre", 4'b0001, 4'b0000);
        chk("pre_gnt0", int'(gnt0), 1);

        // Reset in the middle of cache 1's grant
        cyc("mid", 4'b0010, 4'b0000);
        cyc("mid", 4'b0010, 4'b0000);
        chk("mid_gnt1", int'(gnt0), 2);
        #3;
        do_reset();
        chk("mid_rst_gnt", int'(gnt0), 0);
        cyc("mid_after", 4'b0010, 4'b0000);
        chk("mid_after_gnt", int'(gnt0), 2);
        chk("mid_after_id", int'(id0), 1);

        // MAX_HOLD=1: a lone requester toggles every cycle
        for (int c = 0; c < 10; c++) begin
            cyc("mh1", 4'b0000, 4'b0001);
            chk("mh1_onehot", $onehot0(gnt1) ? 1 : 0, 1);
        end

        // Randomized traffic on both instances
        r   = '0;
        r_b = '0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) r   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r_b = 4'($urandom_range(0, 15));
            cyc("rnd", r, r_b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
